clk_div_bank: RTL and testbench



---
 rtl/clk_div_bank.sv | 121 ++++++++++++
 tb/tb_clk_div_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// clk_div_bank : bank of independent, runtime-retunable clock dividers
// Rev 1.0 - initial release
// ============================================================================
module clk_div_bank #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 18
) (
  input  logic                      clock_in,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CNT_W-1:0]          div_value,
  output logic [CHANNELS-1:0]       clock_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS*CNT_W-1:0] active_div
);

  localparam logic [CNT_W-1:0] C_DEFAULT = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] w_clamped;
  assign w_clamped = (div_value < C_MIN_DIV) ? C_MIN_DIV : div_value;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_n;
      logic [CNT_W-1:0] r_p;
      logic             r_run;
      logic             r_pend;
      logic             r_clk;
      logic             r_tick;

      logic [CNT_W-1:0] w_cnt_nxt;
      logic [CNT_W-1:0] w_n_nxt;
      logic [CNT_W-1:0] w_p_nxt;
      logic [CNT_W-1:0] w_h_nxt;
      logic             w_run_nxt;
      logic             w_pend_nxt;
      logic             w_boundary;

      assign w_boundary = (r_cnt == (r_n - C_ONE));

      // The ratio only changes at a period boundary, on stop, or while idle,
      // so a running period is never cut short or stretched.
      always_comb begin
        w_cnt_nxt  = r_cnt;
        w_n_nxt    = r_n;
        w_p_nxt    = r_p;
        w_run_nxt  = r_run;
        w_pend_nxt = r_pend;
        if (!r_run) begin
          w_cnt_nxt  = '0;
          w_pend_nxt = 1'b0;
          if (load[g]) begin
            w_n_nxt = w_clamped;
          end
          if (enable[g]) begin
            w_run_nxt = 1'b1;
          end
        end else if (!enable[g]) begin
          w_run_nxt  = 1'b0;
          w_cnt_nxt  = '0;
          w_pend_nxt = 1'b0;
          if (load[g]) begin
            w_n_nxt = w_clamped;
          end else if (r_pend) begin
            w_n_nxt = r_p;
          end
        end else if (w_boundary) begin
          w_cnt_nxt  = '0;
          w_pend_nxt = 1'b0;
          if (load[g]) begin
            w_n_nxt = w_clamped;
          end else if (r_pend) begin
            w_n_nxt = r_p;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
          if (load[g]) begin
            w_p_nxt    = w_clamped;
            w_pend_nxt = 1'b1;
          end
        end
      end

      // ceil(N/2) without needing an extra carry bit
      assign w_h_nxt = (w_n_nxt >> 1) + {{(CNT_W-1){1'b0}}, w_n_nxt[0]};

      always_ff @(posedge clock_in) begin
        if (reset) begin
          r_cnt  <= '0;
          r_n    <= C_DEFAULT;
          r_p    <= C_DEFAULT;
          r_run  <= 1'b0;
          r_pend <= 1'b0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_n    <= w_n_nxt;
          r_p    <= w_p_nxt;
          r_run  <= w_run_nxt;
          r_pend <= w_pend_nxt;
          r_clk  <= w_run_nxt && (w_cnt_nxt < w_h_nxt);
          r_tick <= w_run_nxt && (w_cnt_nxt == '0);
        end
      end

      assign clock_out[g]                 = r_clk;
      assign tick[g]                      = r_tick;
      assign active_div[g*CNT_W +: CNT_W] = r_n;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// tb_clk_div_bank : vector table, directed corner cases and random run
// Rev 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int DEF = 18;

  logic          clock_in = 1'b0;
  logic          reset;
  logic [CH-1:0] enable;
  logic [CH-1:0] load;
  logic [W-1:0]  div_value;
  logic [CH-1:0] clock_out;
  logic [CH-1:0] tick;
  logic [CH*W-1:0] active_div;

  always #5 clock_in = ~clock_in;

  clk_div_bank #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .div_value  (div_value),
    .clock_out  (clock_out),
    .tick       (tick),
    .active_div (active_div)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: position within the current period plus ratio bookkeeping.
  int m_run [CH];
  int m_ph  [CH];
  int m_n   [CH];
  int m_p   [CH];
  int m_pend[CH];

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [CH-1:0] en,
                            input logic [CH-1:0] ld, input int dv);
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        m_run[c] = 0; m_ph[c] = 0; m_n[c] = DEF; m_pend[c] = 0;
      end else if (m_run[c] == 0) begin
        if (ld[c]) m_n[c] = clampv(dv);
        if (en[c]) begin m_run[c] = 1; m_ph[c] = 0; end
      end else if (!en[c]) begin
        m_run[c] = 0; m_ph[c] = 0;
        if (ld[c]) m_n[c] = clampv(dv);
        else if (m_pend[c] != 0) m_n[c] = m_p[c];
        m_pend[c] = 0;
      end else if (m_ph[c] == m_n[c] - 1) begin
        m_ph[c] = 0;
        if (ld[c]) m_n[c] = clampv(dv);
        else if (m_pend[c] != 0) m_n[c] = m_p[c];
        m_pend[c] = 0;
      end else begin
        m_ph[c]++;
        if (ld[c]) begin m_p[c] = clampv(dv); m_pend[c] = 1; end
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s clock_out[%0d]", tag, c), int'(clock_out[c]),
          (m_run[c] != 0 && m_ph[c] < (m_n[c] + 1) / 2) ? 1 : 0);
      chk($sformatf("%s tick[%0d]", tag, c), int'(tick[c]),
          (m_run[c] != 0 && m_ph[c] == 0) ? 1 : 0);
      chk($sformatf("%s active_div[%0d]", tag, c), int'(active_div[c*W +: W]), m_n[c]);
    end
  endtask

  task automatic step(input logic r, input logic [CH-1:0] en,
                      input logic [CH-1:0] ld, input logic [W-1:0] dv);
    reset = r; enable = en; load = ld; div_value = dv;
    @(posedge clock_in);
    model_edge(r, en, ld, int'(dv));
    #1;
  endtask

  // Returns the number of edges until tick[ch] shows, or -1 if it never does.
  task automatic steps_to_tick(input int ch, input logic [CH-1:0] en,
                               input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      if (k < 0) begin
        step(1'b0, en, 2'b00, 8'd0);
        check_model("run");
        if (tick[ch]) k = i;
      end
    end
  endtask

  typedef struct {
    logic          r;
    logic [CH-1:0] en;
    logic [CH-1:0] ld;
    logic [W-1:0]  dv;
    logic [CH-1:0] co;
    logic [CH-1:0] tk;
    logic [W-1:0]  d0;
    logic [W-1:0]  d1;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int k;
    logic [CH-1:0] ren;
    logic [CH-1:0] rld;

    tbl[0]  = '{1'b1, 2'b00, 2'b00, 8'd0, 2'b00, 2'b00, 8'd18, 8'd18};
    tbl[1]  = '{1'b0, 2'b00, 2'b01, 8'd5, 2'b00, 2'b00, 8'd5,  8'd18};
    tbl[2]  = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b01, 2'b01, 8'd5,  8'd18};
    tbl[3]  = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b01, 2'b00, 8'd5,  8'd18};
    tbl[4]  = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b01, 2'b00, 8'd5,  8'd18};
    tbl[5]  = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b00, 2'b00, 8'd5,  8'd18};
    tbl[6]  = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b00, 2'b00, 8'd5,  8'd18};
    tbl[7]  = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b01, 2'b01, 8'd5,  8'd18};
    tbl[8]  = '{1'b0, 2'b01, 2'b01, 8'd2, 2'b01, 2'b00, 8'd5,  8'd18};
    tbl[9]  = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b01, 2'b00, 8'd5,  8'd18};
    tbl[10] = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b00, 2'b00, 8'd5,  8'd18};
    tbl[11] = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b00, 2'b00, 8'd5,  8'd18};
    tbl[12] = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b01, 2'b01, 8'd2,  8'd18};
    tbl[13] = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b00, 2'b00, 8'd2,  8'd18};
    tbl[14] = '{1'b0, 2'b01, 2'b00, 8'd0, 2'b01, 2'b01, 8'd2,  8'd18};
    tbl[15] = '{1'b0, 2'b00, 2'b00, 8'd0, 2'b00, 2'b00, 8'd2,  8'd18};
    tbl[16] = '{1'b0, 2'b00, 2'b11, 8'd0, 2'b00, 2'b00, 8'd2,  8'd2};
    tbl[17] = '{1'b0, 2'b00, 2'b10, 8'd9, 2'b00, 2'b00, 8'd2,  8'd9};
    tbl[18] = '{1'b0, 2'b00, 2'b10, 8'd1, 2'b00, 2'b00, 8'd2,  8'd2};
    tbl[19] = '{1'b0, 2'b10, 2'b00, 8'd0, 2'b10, 2'b10, 8'd2,  8'd2};
    tbl[20] = '{1'b0, 2'b10, 2'b00, 8'd0, 2'b00, 2'b00, 8'd2,  8'd2};
    tbl[21] = '{1'b0, 2'b10, 2'b00, 8'd0, 2'b10, 2'b10, 8'd2,  8'd2};
    tbl[22] = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b00, 2'b00, 8'd18, 8'd18};

    reset = 1'b1; enable = '0; load = '0; div_value = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_ph[c] = 0; m_n[c] = DEF; m_p[c] = DEF; m_pend[c] = 0;
    end

    // Default ratio: 9 high / 9 low with a tick every 18 cycles
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 2'b00, 8'd0);
    check_model("reset");
    for (int i = 0; i < 36; i++) begin
      step(1'b0, 2'b01, 2'b00, 8'd0);
      chk($sformatf("default pattern clock_out[0] @%0d", i), int'(clock_out[0]),
          ((i % 18) < 9) ? 1 : 0);
      chk($sformatf("default pattern tick[0] @%0d", i), int'(tick[0]),
          ((i % 18) == 0) ? 1 : 0);
      check_model("default");
    end

    // Table of hand-computed vectors
    step(1'b1, 2'b00, 2'b00, 8'd0);
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].en, tbl[i].ld, tbl[i].dv);
      chk($sformatf("vec%0d clock_out", i), int'(clock_out), int'(tbl[i].co));
      chk($sformatf("vec%0d tick", i), int'(tick), int'(tbl[i].tk));
      chk($sformatf("vec%0d active_div0", i), int'(active_div[7:0]), int'(tbl[i].d0));
      chk($sformatf("vec%0d active_div1", i), int'(active_div[15:8]), int'(tbl[i].d1));
    end

    // Retune mid-period: N=10, load 4 while cnt=3
    step(1'b1, 2'b00, 2'b00, 8'd0);
    step(1'b0, 2'b00, 2'b01, 8'd10);
    step(1'b0, 2'b01, 2'b00, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 2'b00, 8'd0);
    step(1'b0, 2'b01, 2'b01, 8'd4);
    chk("retune still old ratio", int'(active_div[7:0]), 10);
    steps_to_tick(0, 2'b01, 20, k);
    chk("retune rest of 10-period", k, 6);
    chk("retune new ratio at boundary", int'(active_div[7:0]), 4);
    steps_to_tick(0, 2'b01, 20, k);
    chk("retune next period length", k, 4);

    // Load in the boundary cycle itself (cnt=9)
    step(1'b1, 2'b00, 2'b00, 8'd0);
    step(1'b0, 2'b00, 2'b01, 8'd10);
    step(1'b0, 2'b01, 2'b00, 8'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 2'b01, 2'b00, 8'd0);
    step(1'b0, 2'b01, 2'b01, 8'd4);
    chk("boundary load tick", int'(tick[0]), 1);
    chk("boundary load ratio", int'(active_div[7:0]), 4);
    steps_to_tick(0, 2'b01, 20, k);
    chk("boundary load period", k, 4);

    // Two channels, independent, channel 0 stopped mid-period
    step(1'b1, 2'b00, 2'b00, 8'd0);
    step(1'b0, 2'b00, 2'b01, 8'd3);
    step(1'b0, 2'b00, 2'b10, 8'd7);
    step(1'b0, 2'b11, 2'b00, 8'd0);
    check_model("dual start");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b11, 2'b00, 8'd0);
      check_model("dual");
    end
    step(1'b0, 2'b10, 2'b00, 8'd0);
    chk("stop clock_out[0]", int'(clock_out[0]), 0);
    chk("stop tick[0]", int'(tick[0]), 0);
    check_model("stop");
    steps_to_tick(1, 2'b10, 20, k);
    steps_to_tick(1, 2'b10, 20, k);
    chk("ch1 period after ch0 stop", k, 7);

    // Reset mid-period with a pending load
    step(1'b1, 2'b00, 2'b00, 8'd0);
    step(1'b0, 2'b00, 2'b01, 8'd10);
    step(1'b0, 2'b01, 2'b00, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 2'b00, 8'd0);
    step(1'b0, 2'b01, 2'b01, 8'd4);
    step(1'b0, 2'b01, 2'b00, 8'd0);
    step(1'b1, 2'b01, 2'b00, 8'd0);
    chk("midreset clock_out[0]", int'(clock_out[0]), 0);
    chk("midreset tick[0]", int'(tick[0]), 0);
    chk("midreset active_div[0]", int'(active_div[7:0]), 18);
    step(1'b0, 2'b01, 2'b00, 8'd0);
    chk("restart tick[0]", int'(tick[0]), 1);
    chk("restart clock_out[0]", int'(clock_out[0]), 1);
    steps_to_tick(0, 2'b01, 40, k);
    chk("restart period ignores discarded load", k, 18);

    // Random run against the reference
    ren = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) ren[c] = ~ren[c];
        rld[c] = ($urandom_range(0, 9) == 0);
      end
      step(($urandom_range(0, 499) == 0), ren, rld,
           ($urandom_range(0, 19) == 0) ? 8'($urandom_range(200, 255))
                                        : 8'($urandom_range(0, 12)));
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
